mem_arbiter: RTL and testbench

- Shares one single-port unified memory among three requesters: instruction fetch (port 0), data load/store (port 1) and the debug/program loader (port 2).
- Sits between the core's fetch/load-store paths and the memory backend.
- Rotates priority round-robin among the three ports and serialises one transaction at a time.
- Aborts any transaction the backend does not acknowledge within a bounded number of cycles.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/rr_pick3.sv | 29 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, FSM state type and port-rotation helper for the memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned PORT_W    = 2;

    localparam logic [PORT_W-1:0] PORT_FETCH = 2'd0;
    localparam logic [PORT_W-1:0] PORT_DATA  = 2'd1;
    localparam logic [PORT_W-1:0] PORT_DBG   = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Next port in rotation order; the unused code 3 folds back to fetch.
    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
        logic [PORT_W-1:0] n;
        if (p == PORT_FETCH) begin
            n = PORT_DATA;
        end else if (p == PORT_DATA) begin
            n = PORT_DBG;
        end else begin
            n = PORT_FETCH;
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: first requester after 'last' in rotation order wins.
module rr_pick3
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last,
    output logic [NUM_PORTS-1:0] pick,
    output logic [PORT_W-1:0]    index
);

    // Walk the ports starting just after the previous winner.
    always_comb begin
        logic [PORT_W-1:0] cand;
        logic              found;
        pick  = '0;
        index = '0;
        found = 1'b0;
        cand  = next_port(last);
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                index       = cand;
            end
            cand = next_port(cand);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among fetch, data and debug
// requesters; one transaction in flight, aborted after TIMEOUT unacknowledged cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]          gnt,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W/8-1:0]           mem_wstrb,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_t                state, state_d;
    logic [PORT_W-1:0]     last_gnt, last_gnt_d;
    logic [TO_W-1:0]       cnt, cnt_d;
    logic [NUM_PORTS-1:0]  gnt_d, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_d;
    logic                  rsp_err_d;
    logic                  mem_req_d, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_d;
    logic [STRB_W-1:0]     mem_wstrb_d;

    logic [NUM_PORTS-1:0]  win_pick;
    logic [PORT_W-1:0]     win_idx;
    logic                  timeout_hit;

    rr_pick3 u_pick (
        .req   (req),
        .last  (last_gnt),
        .pick  (win_pick),
        .index (win_idx)
    );

    // Abort point: counter reaches TIMEOUT-1 in BUSY (disabled when TIMEOUT is 0).
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = (cnt == TO_W'(TIMEOUT - 1));
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state;
        last_gnt_d  = last_gnt;
        cnt_d       = cnt;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wstrb_d = mem_wstrb;

        case (state)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d     = ST_BUSY;
                    last_gnt_d  = win_idx;
                    cnt_d       = '0;
                    gnt_d       = win_pick;
                    mem_req_d   = 1'b1;
                    mem_we_d    = (win_idx == PORT_FETCH) ? 1'b0 : req_we[win_idx];
                    mem_addr_d  = req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[32'(win_idx) * DATA_W +: DATA_W];
                    mem_wstrb_d = req_wstrb[32'(win_idx) * STRB_W +: STRB_W];
                end
            end
            ST_BUSY: begin
                cnt_d = cnt + TO_W'(1);
                if (mem_ack) begin
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = NUM_PORTS'(1) << last_gnt;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = mem_we ? '0 : mem_rdata;
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = NUM_PORTS'(1) << last_gnt;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_gnt  <= PORT_DBG;
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state     <= state_d;
            last_gnt  <= last_gnt_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wstrb <= mem_wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin / timeout model.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TMO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req, req_we;
    logic [3*AW-1:0]   req_addr;
    logic [3*DW-1:0]   req_wdata;
    logic [3*SW-1:0]   req_wstrb;
    logic [2:0]        gnt, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              mem_req, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_wstrb;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;

    int checks = 0;
    int failures = 0;
    int model_last;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .TO_W(3)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, rsp_valid, rsp_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs gnt=%b rsp_valid=%b mem_req=%b mem_addr=%h rdata=%h expected all zero",
                     gnt, rsp_valid, mem_req, mem_addr, rsp_rdata);
        end
        rst = 1'b0;
        model_last = 2;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        req = 3'b001; req_addr[0 +: AW] = 32'h10;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL fetch_grant gnt=%b mem_req=%b addr=%h we=%b expected 001/1/00000010/0", gnt, mem_req, mem_addr, mem_we);
        end
        req = '0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (rsp_valid !== 3'b001 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || mem_req !== 1'b0 || gnt !== 3'b000) begin
            failures++;
            $display("FAIL fetch_rsp rsp_valid=%b rdata=%h err=%b mem_req=%b gnt=%b expected 001/deadbeef/0/0/000",
                     rsp_valid, rsp_rdata, rsp_err, mem_req, gnt);
        end
        model_last = 0;
    endtask

    task automatic test_contention();
        logic [2:0] exp_g, exp_r;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 2;
        req = 3'b111;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_g = (i % 2 == 0 && i < 8) ? (3'b001 << ((i / 2) % 3)) : 3'b000;
            exp_r = (i % 2 == 1) ? (3'b001 << (((i - 1) / 2) % 3)) : 3'b000;
            checks++;
            if (gnt !== exp_g || rsp_valid !== exp_r) begin
                failures++;
                $display("FAIL contention_c%0d gnt=%b rsp_valid=%b expected %b/%b", i, gnt, rsp_valid, exp_g, exp_r);
            end
            mem_ack = (i % 2 == 0) && (i < 8);
            if (i == 7) req = '0;
        end
        mem_ack = 1'b0;
        model_last = 0;
    endtask

    task automatic test_write();
        req = 3'b010; req_we = 3'b010;
        req_addr[AW +: AW] = 32'h100; req_wdata[DW +: DW] = 32'h12345678; req_wstrb[SW +: SW] = 4'b0011;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h12345678 || mem_wstrb !== 4'b0011) begin
            failures++;
            $display("FAIL write_cmd gnt=%b we=%b addr=%h wdata=%h wstrb=%b expected 010/1/100/12345678/0011",
                     gnt, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        req = '0; req_we = '0;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || rsp_valid !== 3'b000) begin
                failures++;
                $display("FAIL write_hold_c%0d mem_req=%b rsp_valid=%b expected 1/000", c, mem_req, rsp_valid);
            end
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL write_rsp rsp_valid=%b rdata=%h err=%b mem_req=%b expected 010/0/0/0", rsp_valid, rsp_rdata, rsp_err, mem_req);
        end
        model_last = 1;
    endtask

    task automatic test_timeout();
        req = 3'b100; req_we = 3'b000; req_addr[2*AW +: AW] = 32'h2000;
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clk);
            if (c == 1) req = '0;
            checks++;
            if (mem_req !== 1'b1 || rsp_valid !== 3'b000) begin
                failures++;
                $display("FAIL timeout_hold_c%0d mem_req=%b rsp_valid=%b expected 1/000", c, mem_req, rsp_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b100 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rsp rsp_valid=%b err=%b rdata=%h mem_req=%b expected 100/1/0/0", rsp_valid, rsp_err, rsp_rdata, mem_req);
        end
        model_last = 2;
    endtask

    task automatic test_ack_at_timeout();
        req = 3'b001; req_addr[0 +: AW] = 32'h44;
        repeat (TMO - 1) @(negedge clk);
        req = '0;
        mem_ack = 1'b1; mem_rdata = 32'hA5A50F0F;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (rsp_valid !== 3'b001 || rsp_err !== 1'b0 || rsp_rdata !== 32'hA5A50F0F) begin
            failures++;
            $display("FAIL ack_at_timeout rsp_valid=%b err=%b rdata=%h expected 001/0/a5a50f0f", rsp_valid, rsp_err, rsp_rdata);
        end
        model_last = 0;
    endtask

    task automatic test_reset_busy();
        req = 3'b010; req_we = '0; req_addr[AW +: AW] = 32'h300;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || rsp_valid !== 3'b000 || gnt !== 3'b000) begin
            failures++;
            $display("FAIL reset_busy_async mem_req=%b rsp_valid=%b gnt=%b expected 0/000/000", mem_req, rsp_valid, gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL reset_busy_regrant gnt=%b rsp_valid=%b expected 001/000", gnt, rsp_valid);
        end
        req = '0; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (rsp_valid !== 3'b001 || rsp_rdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL reset_busy_rsp rsp_valid=%b rdata=%h expected 001/0badf00d", rsp_valid, rsp_rdata);
        end
        model_last = 0;
    endtask

    // Random traffic; ports keep requests pending until granted, backend delays vary.
    task automatic test_random(input int n);
        logic [2:0]  pend, newb, a_we;
        logic [31:0] a_addr [3];
        logic [31:0] a_wdata [3];
        logic [3:0]  a_wstrb [3];
        pend = '0; a_we = '0;
        for (int p = 0; p < 3; p++) begin
            a_addr[p] = '0; a_wdata[p] = '0; a_wstrb[p] = '0;
        end
        for (int t = 0; t < n; t++) begin
            int          win, ack_cyc;
            logic [31:0] rd, exp_rd;
            logic        exp_we, exp_err;
            newb = 3'($urandom_range(0, 7)) & ~pend;
            if ((pend | newb) == 3'b000) newb = 3'b001 << $urandom_range(0, 2);
            for (int p = 0; p < 3; p++) begin
                if (newb[p]) begin
                    a_we[p] = 1'($urandom_range(0, 1));
                    a_addr[p] = $urandom; a_wdata[p] = $urandom; a_wstrb[p] = 4'($urandom_range(0, 15));
                end
            end
            pend = pend | newb;
            req = pend; req_we = a_we;
            for (int p = 0; p < 3; p++) begin
                req_addr[p*AW +: AW] = a_addr[p];
                req_wdata[p*DW +: DW] = a_wdata[p];
                req_wstrb[p*SW +: SW] = a_wstrb[p];
            end
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            win = -1;
            for (int k = 1; k <= 3; k++) begin
                if (win < 0 && pend[(model_last + k) % 3]) win = (model_last + k) % 3;
            end
            exp_we = (win == 0) ? 1'b0 : a_we[win];
            @(negedge clk);
            checks++;
            if (gnt !== (3'b001 << win) || mem_req !== 1'b1 || rsp_valid !== 3'b000 || mem_we !== exp_we ||
                mem_addr !== a_addr[win] || mem_wdata !== a_wdata[win] || mem_wstrb !== a_wstrb[win]) begin
                failures++;
                $display("FAIL rand_grant_t%0d gnt=%b we=%b addr=%h wdata=%h wstrb=%b expected port %0d we=%b addr=%h wdata=%h wstrb=%b",
                         t, gnt, mem_we, mem_addr, mem_wdata, mem_wstrb, win, exp_we, a_addr[win], a_wdata[win], a_wstrb[win]);
            end
            pend[win] = 1'b0;
            req = pend;
            model_last = win;
            ack_cyc = $urandom_range(0, TMO);
            rd = '0;
            for (int c = 1; c <= TMO; c++) begin
                if (c > 1) begin
                    @(negedge clk);
                    checks++;
                    if (mem_req !== 1'b1 || rsp_valid !== 3'b000 || gnt !== 3'b000) begin
                        failures++;
                        $display("FAIL rand_busy_t%0d_c%0d mem_req=%b rsp_valid=%b gnt=%b expected 1/000/000", t, c, mem_req, rsp_valid, gnt);
                    end
                end
                mem_ack = (c == ack_cyc);
                mem_rdata = $urandom;
                if (c == ack_cyc) begin
                    rd = mem_rdata;
                    break;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            exp_err = (ack_cyc == 0);
            exp_rd = (exp_err || exp_we) ? 32'h0 : rd;
            checks++;
            if (rsp_valid !== (3'b001 << win) || rsp_err !== exp_err || rsp_rdata !== exp_rd || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL rand_rsp_t%0d rsp_valid=%b err=%b rdata=%h mem_req=%b expected port %0d err=%b rdata=%h",
                         t, rsp_valid, rsp_err, rsp_rdata, mem_req, win, exp_err, exp_rd);
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_write();
        test_timeout();
        test_ack_at_timeout();
        test_reset_busy();
        test_random(80);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
